// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: next-PC select codes, fetch FSM states and instruction size
package cpu_fetch_pkg;
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_FAULT} fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection (seq, branch, jump, register)
//   in:  pc, pc_src, imm16 (word offset), j_target, reg_target
//   out: next_pc, pc_plus4
module next_pc_calc
  import cpu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [15:0] imm16,
  input  logic [25:0] j_target,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);
  logic [31:0] br_off;
  assign pc_plus4 = pc + 32'(INSTR_BYTES);
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
  always_comb
    next_pc = pc_src == PC_SEQ    ? pc_plus4 :
              pc_src == PC_BRANCH ? pc_plus4 + br_off :
              pc_src == PC_JUMP   ? {pc_plus4[31:28], j_target, 2'b00} :
                                    reg_target;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IR latch for a big-endian instruction memory
//   in:  CLK, Reset (async), FetchReq, IRAck, PCWrite, PCSrc, Imm16, JTarget, RegTarget, IDataIn
//   out: IAddr (=PC), IR, IRValid, PC, PCPlus4, Busy (in WAIT), Fault (sticky bad fetch)
module instruction_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 128,
  parameter int          MEM_WAIT  = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        FetchReq,
  input  logic        IRAck,
  input  logic        PCWrite,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Imm16,
  input  logic [25:0] JTarget,
  input  logic [31:0] RegTarget,
  input  logic [31:0] IDataIn,
  output logic [31:0] IAddr,
  output logic [31:0] IR,
  output logic        IRValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Busy,
  output logic        Fault
);
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - INSTR_BYTES);
  fetch_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, next_pc;
  logic        ir_valid_q, ir_valid_d, busy_q, busy_d, fault_q, fault_d, legal;
  next_pc_calc u_next_pc (
    .pc        (pc_q),
    .pc_src    (PCSrc),
    .imm16     (Imm16),
    .j_target  (JTarget),
    .reg_target(RegTarget),
    .next_pc   (next_pc),
    .pc_plus4  (PCPlus4)
  );
  assign legal = pc_q[1:0] == 2'b00 && pc_q <= LAST_ADDR;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      S_IDLE: begin
        if (PCWrite) pc_d = next_pc;
        else if (FetchReq) begin
          state_d = legal ? S_WAIT : S_FAULT;
          cnt_d   = 4'(MEM_WAIT);
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          ir_d       = IDataIn;
          ir_valid_d = 1'b1;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (PCWrite) pc_d = next_pc;
        if (IRAck) begin
          ir_valid_d = 1'b0;
          cnt_d      = 4'(MEM_WAIT);
          state_d    = !(FetchReq && !PCWrite) ? S_IDLE : legal ? S_WAIT : S_FAULT;
        end
      end
      default: ir_valid_d = 1'b0;
    endcase
    busy_d  = state_d == S_WAIT;
    fault_d = state_d == S_FAULT;
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  assign IAddr   = pc_q;
  assign PC      = pc_q;
  assign IR      = ir_q;
  assign IRValid = ir_valid_q;
  assign Busy    = busy_q;
  assign Fault   = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for zero-wait and two-wait fetch units
module tb_instruction_fetch_unit;
  import cpu_fetch_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, fetch_req, ir_ack, pc_write;
  logic [1:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] j_target;
  logic [31:0] reg_target;
  logic [31:0] iaddr_a, idata_a, ir_a, pc_a, pcp4_a;
  logic [31:0] iaddr_b, idata_b, ir_b, pc_b, pcp4_b;
  logic        irv_a, busy_a, fault_a, irv_b, busy_b, fault_b;
  logic [7:0]  mem [0:127];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  int checks = 0, errors = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [6:0] i;
    i = a[6:0];
    return (a <= 32'd124) ? {mem[i], mem[i + 7'd1], mem[i + 7'd2], mem[i + 7'd3]} : 32'h0;
  endfunction
  assign idata_a = rd(iaddr_a);
  assign idata_b = rd(iaddr_b);
  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(128), .MEM_WAIT(0)) dut_a (
    .CLK(clk), .Reset(rst_a), .FetchReq(fetch_req), .IRAck(ir_ack), .PCWrite(pc_write),
    .PCSrc(pc_src), .Imm16(imm16), .JTarget(j_target), .RegTarget(reg_target),
    .IDataIn(idata_a), .IAddr(iaddr_a), .IR(ir_a), .IRValid(irv_a), .PC(pc_a),
    .PCPlus4(pcp4_a), .Busy(busy_a), .Fault(fault_a));
  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(128), .MEM_WAIT(2)) dut_b (
    .CLK(clk), .Reset(rst_b), .FetchReq(fetch_req), .IRAck(ir_ack), .PCWrite(pc_write),
    .PCSrc(pc_src), .Imm16(imm16), .JTarget(j_target), .RegTarget(reg_target),
    .IDataIn(idata_b), .IAddr(iaddr_b), .IR(ir_b), .IRValid(irv_b), .PC(pc_b),
    .PCPlus4(pcp4_b), .Busy(busy_b), .Fault(fault_b));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (irv_a && !prev_a) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_a unexpected IR %h want none", ir_a);
      end else chk("sb_a_ir", ir_a, exp_a.pop_front());
    end
    if (irv_b && !prev_b) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_b unexpected IR %h want none", ir_b);
      end else chk("sb_b_ir", ir_b, exp_b.pop_front());
    end
    prev_a = irv_a;
    prev_b = irv_b;
  end
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    {mem[0], mem[1], mem[2], mem[3]} = 32'h00221800;
    {mem[4], mem[5], mem[6], mem[7]} = 32'h08220224;
    rst_a = 1'b1; rst_b = 1'b1;
    fetch_req = 1'b0; ir_ack = 1'b0; pc_write = 1'b0; pc_src = PC_SEQ;
    imm16 = 16'h0; j_target = 26'h0; reg_target = 32'h0;
    tick(); tick();
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_ir", ir_a, 32'h0);
    chk("rst_irv", 32'(irv_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_fault", 32'(fault_a), 32'd0);
    rst_a = 1'b0;
    fetch_req = 1'b1; exp_a.push_back(32'h00221800);
    chk("t1_iaddr", iaddr_a, 32'h0);
    tick(); fetch_req = 1'b0;
    chk("t1_busy_wait", 32'(busy_a), 32'd1);
    chk("t1_irv_wait", 32'(irv_a), 32'd0);
    tick();
    chk("t1_busy_done", 32'(busy_a), 32'd0);
    chk("t1_irv_done", 32'(irv_a), 32'd1);
    tick();
    chk("t1_irv_hold", 32'(irv_a), 32'd1);
    chk("t1_ir_hold", ir_a, 32'h00221800);
    pc_write = 1'b1; pc_src = PC_SEQ;
    tick(); pc_write = 1'b0;
    chk("t2_pc_seq", pc_a, 32'h4);
    chk("t2_irv_still", 32'(irv_a), 32'd1);
    ir_ack = 1'b1; fetch_req = 1'b1; exp_a.push_back(32'h08220224);
    tick(); ir_ack = 1'b0; fetch_req = 1'b0;
    chk("t2_b2b_busy", 32'(busy_a), 32'd1);
    chk("t2_b2b_irv", 32'(irv_a), 32'd0);
    tick();
    chk("t2_irv", 32'(irv_a), 32'd1);
    pc_write = 1'b1; pc_src = PC_BRANCH; imm16 = 16'hFFFF;
    tick();
    chk("t3_branch", pc_a, 32'h4);
    pc_src = PC_JUMP; j_target = 26'h10;
    tick(); pc_write = 1'b0;
    chk("t3_jump", pc_a, 32'h40);
    chk("t3_iaddr", iaddr_a, 32'h40);
    ir_ack = 1'b1;
    tick(); ir_ack = 1'b0;
    chk("t3_idle_irv", 32'(irv_a), 32'd0);
    chk("t3_idle_busy", 32'(busy_a), 32'd0);
    fetch_req = 1'b1; exp_a.push_back(32'h40414243);
    tick(); fetch_req = 1'b0;
    tick();
    chk("t3_irv_40", 32'(irv_a), 32'd1);
    pc_write = 1'b1; pc_src = PC_REG; reg_target = 32'h7C;
    tick(); pc_write = 1'b0;
    chk("t3_reg", pc_a, 32'h7C);
    chk("t3_pcp4", pcp4_a, 32'h80);
    ir_ack = 1'b1;
    tick(); ir_ack = 1'b0;
    fetch_req = 1'b1; exp_a.push_back(32'h7C7D7E7F);
    tick(); fetch_req = 1'b0;
    tick();
    chk("t3_irv_7c", 32'(irv_a), 32'd1);
    chk("t3_fault_7c", 32'(fault_a), 32'd0);
    ir_ack = 1'b1;
    tick(); ir_ack = 1'b0;
    pc_write = 1'b1; reg_target = 32'h6;
    tick(); pc_write = 1'b0;
    chk("t4_pc6", pc_a, 32'h6);
    fetch_req = 1'b1;
    tick(); fetch_req = 1'b0;
    chk("t4_fault", 32'(fault_a), 32'd1);
    chk("t4_irv", 32'(irv_a), 32'd0);
    chk("t4_busy", 32'(busy_a), 32'd0);
    pc_write = 1'b1; fetch_req = 1'b1; reg_target = 32'h0;
    tick(); tick(); pc_write = 1'b0; fetch_req = 1'b0;
    chk("t4_pc_ignored", pc_a, 32'h6);
    chk("t4_fault_sticky", 32'(fault_a), 32'd1);
    chk("t4_irv_sticky", 32'(irv_a), 32'd0);
    rst_a = 1'b1; #1;
    chk("t4_rst_fault", 32'(fault_a), 32'd0);
    chk("t4_rst_pc", pc_a, 32'h0);
    tick(); rst_a = 1'b0;
    pc_write = 1'b1; reg_target = 32'h80;
    tick(); pc_write = 1'b0;
    chk("t4_pc80", pc_a, 32'h80);
    fetch_req = 1'b1;
    tick(); fetch_req = 1'b0;
    chk("t4_fault_80", 32'(fault_a), 32'd1);
    rst_a = 1'b1;
    tick(); rst_a = 1'b0;
    pc_write = 1'b1; reg_target = 32'hFFFF_FFFC;
    tick(); pc_write = 1'b0;
    chk("t4_pcp4_wrap", pcp4_a, 32'h0);
    fetch_req = 1'b1;
    tick(); fetch_req = 1'b0;
    chk("t4_fault_top", 32'(fault_a), 32'd1);
    rst_a = 1'b1;
    rst_b = 1'b0; pc_src = PC_SEQ;
    chk("t5_rst_pc", pc_b, 32'h0);
    pc_write = 1'b1;
    tick(); pc_write = 1'b0;
    chk("t5_pc4", pc_b, 32'h4);
    fetch_req = 1'b1; exp_b.push_back(32'h08220224);
    tick(); fetch_req = 1'b0;
    chk("t5_busy_k", 32'(busy_b), 32'd1);
    chk("t5_irv_k", 32'(irv_b), 32'd0);
    pc_write = 1'b1; pc_src = PC_JUMP; j_target = 26'h10;
    tick();
    chk("t5_pc_k1", pc_b, 32'h4);
    chk("t5_iaddr_k1", iaddr_b, 32'h4);
    chk("t5_irv_k1", 32'(irv_b), 32'd0);
    tick(); pc_write = 1'b0;
    chk("t5_pc_k2", pc_b, 32'h4);
    chk("t5_irv_k2", 32'(irv_b), 32'd0);
    chk("t5_busy_k2", 32'(busy_b), 32'd1);
    tick();
    chk("t5_irv_k3", 32'(irv_b), 32'd1);
    chk("t5_busy_k3", 32'(busy_b), 32'd0);
    ir_ack = 1'b1;
    tick(); ir_ack = 1'b0;
    fetch_req = 1'b1;
    tick(); fetch_req = 1'b0;
    tick();
    chk("t6_busy_pre", 32'(busy_b), 32'd1);
    #2 rst_b = 1'b1; #1;
    chk("t6_pc", pc_b, 32'h0);
    chk("t6_irv", 32'(irv_b), 32'd0);
    chk("t6_busy", 32'(busy_b), 32'd0);
    chk("t6_ir", ir_b, 32'h0);
    tick(); tick();
    chk("t6_ir_later", ir_b, 32'h0);
    chk("t6_irv_later", 32'(irv_b), 32'd0);
    rst_b = 1'b0;
    tick();
    chk("sb_a_empty", 32'(exp_a.size()), 32'd0);
    chk("sb_b_empty", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
